seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a bank of 7-segment digits sharing one segment bus. It accepts a packed nibble vector, decodes each nibble in decimal or hexadecimal mode, and scans the digits one at a time with a programmable dwell. It provides double-buffered loading so the display never tears mid-frame. It sits between the datapath's numeric outputs and the board's segment/anode pins, replacing per-digit combinational decoders.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_driver_if.sv | 26 ++
 rtl/seg7_decode.sv | 23 ++
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   - segment bit order (bit 0 = a ... bit 6 = g)
//   - the sixteen active-high digit patterns and the blank pattern
//   - polarity helper used when driving common-anode parts
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Active-high patterns indexed by nibble value: 0-9, then A b C d E F.
    localparam seg_t SEG_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Convert an active-high pattern to the pin level of the target part.
    function automatic seg_t seg_pol(input seg_t pat, input bit active_low);
        seg_t res;
        if (active_low) begin
            res = ~pat;
        end else begin
            res = pat;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display-data bundle between the datapath and the driver.
//   enable, load, value, dp_in, blank_lz : datapath -> driver
//   seg, dp, an, frame                   : driver -> pins / datapath
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  seg, dp, an, frame
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble -> active-high 7-segment pattern.
//   nibble  : value 0..15
//   pattern : segments a..g (bit 0 = a); 10-15 blank unless HEX_EN
module seg7_decode
    import seg7_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [3:0] nibble,
    output seg_t       pattern
);

    // Table lookup, with the hex range optionally blanked.
    always_comb begin
        pattern = SEG_BLANK;
        if (!HEX_EN && (nibble > 4'd9)) begin
            pattern = SEG_BLANK;
        end else begin
            pattern = SEG_PAT[nibble];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS 7-segment digits.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg7_scan_driver_if.slave
//                in : enable, load, value[4*DIGITS], dp_in[DIGITS], blank_lz
//                out: seg[7], dp, an[DIGITS] (one-hot), frame (frame-start pulse)
// Loads go to a pending buffer; the active buffer (value, dp, blank_lz)
// is refreshed only at frame start so a frame never mixes two values.
// Outputs are registered from the next-state index and next active buffer,
// so seg/dp/an change on the same edge as the index.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter bit HEX_EN         = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
    localparam seg_t              SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]         presc_r, presc_nxt_s;
    logic [IW-1:0]         idx_r, idx_nxt_s;
    logic [4*DIGITS-1:0]   pend_val_r, act_val_r, src_val_s, act_val_nxt_s;
    logic [DIGITS-1:0]     pend_dp_r, act_dp_r, src_dp_s, act_dp_nxt_s;
    logic                  act_blz_r, act_blz_nxt_s;
    logic                  en_d_r;
    logic                  rise_s, wrap_s, fstart_s;
    logic [3:0]            nib_s;
    logic                  dp_sel_s, any_nz_s, suppress_s;
    seg_t                  pat_s;
    seg_t                  seg_r;
    logic                  dp_r, frame_r;
    logic [DIGITS-1:0]     an_r;

    // Scan sequencing: frame-start detection and next prescaler/index.
    always_comb begin
        rise_s      = bus.enable & ~en_d_r;
        wrap_s      = bus.enable & en_d_r & (presc_r == PRE_LAST);
        fstart_s    = rise_s | (wrap_s & (idx_r == IDX_LAST));
        presc_nxt_s = presc_r;
        idx_nxt_s   = idx_r;
        if (!bus.enable || rise_s) begin
            presc_nxt_s = '0;
            idx_nxt_s   = '0;
        end else if (wrap_s) begin
            presc_nxt_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IW'(1);
            end
        end else begin
            presc_nxt_s = presc_r + PW'(1);
            idx_nxt_s   = idx_r;
        end
    end

    // Buffer steering: a load coinciding with frame start bypasses to active.
    always_comb begin
        if (bus.load) begin
            src_val_s = bus.value;
            src_dp_s  = bus.dp_in;
        end else begin
            src_val_s = pend_val_r;
            src_dp_s  = pend_dp_r;
        end
        if (fstart_s) begin
            act_val_nxt_s = src_val_s;
            act_dp_nxt_s  = src_dp_s;
            act_blz_nxt_s = bus.blank_lz;
        end else begin
            act_val_nxt_s = act_val_r;
            act_dp_nxt_s  = act_dp_r;
            act_blz_nxt_s = act_blz_r;
        end
    end

    // Select the upcoming digit and find any nonzero nibble at or above it.
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        any_nz_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx_nxt_s) begin
                nib_s    = act_val_nxt_s[4*k +: 4];
                dp_sel_s = act_dp_nxt_s[k];
            end else begin
                nib_s    = nib_s;
            end
            if ((IW'(k) >= idx_nxt_s) && (act_val_nxt_s[4*k +: 4] != 4'h0)) begin
                any_nz_s = 1'b1;
            end else begin
                any_nz_s = any_nz_s;
            end
        end
        // Digit 0 is always shown, even when the whole value is zero.
        suppress_s = act_blz_nxt_s & (idx_nxt_s != '0) & ~any_nz_s;
    end

    seg7_decode #(
        .HEX_EN (HEX_EN)
    ) u_decode (
        .nibble  (nib_s),
        .pattern (pat_s)
    );

    // Counter, enable-history and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r    <= '0;
            idx_r      <= '0;
            en_d_r     <= 1'b0;
            pend_val_r <= '0;
            pend_dp_r  <= '0;
            act_val_r  <= '0;
            act_dp_r   <= '0;
            act_blz_r  <= 1'b0;
        end else begin
            presc_r    <= presc_nxt_s;
            idx_r      <= idx_nxt_s;
            en_d_r     <= bus.enable;
            pend_val_r <= src_val_s;
            pend_dp_r  <= src_dp_s;
            act_val_r  <= act_val_nxt_s;
            act_dp_r   <= act_dp_nxt_s;
            act_blz_r  <= act_blz_nxt_s;
        end
    end

    // Registered pin outputs, inactive while disabled or in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r   <= SEG_OFF;
            dp_r    <= DP_OFF;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else if (!bus.enable) begin
            seg_r   <= SEG_OFF;
            dp_r    <= DP_OFF;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_pol(suppress_s ? SEG_BLANK : pat_s, SEG_ACTIVE_LOW);
            dp_r    <= dp_sel_s ^ DP_OFF;
            an_r    <= (DIGITS'(1) << idx_nxt_s) ^ AN_OFF;
            frame_r <= fstart_s;
        end
    end

    assign bus.seg   = seg_r;
    assign bus.dp    = dp_r;
    assign bus.an    = an_r;
    assign bus.frame = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: three drivers (DIGITS=4, DIV=4) share one stimulus:
//   u_a HEX_EN=1, u_b HEX_EN=0, u_c SEG_ACTIVE_LOW=1 + AN_ACTIVE_LOW=1.
// Expected per-cycle outputs are pushed into a scoreboard queue from a
// reference decoder and popped/compared on each falling edge.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [6:0] seg_a;
        logic [6:0] seg_b;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_in;
    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(4)) ia ();
    seg7_scan_driver_if #(.DIGITS(4)) ib ();
    seg7_scan_driver_if #(.DIGITS(4)) ic ();

    assign ia.enable = enable;   assign ib.enable = enable;   assign ic.enable = enable;
    assign ia.load = load;       assign ib.load = load;       assign ic.load = load;
    assign ia.value = value;     assign ib.value = value;     assign ic.value = value;
    assign ia.dp_in = dp_in;     assign ib.dp_in = dp_in;     assign ic.dp_in = dp_in;
    assign ia.blank_lz = blank_lz; assign ib.blank_lz = blank_lz; assign ic.blank_lz = blank_lz;

    seg7_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    seg7_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    seg7_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b1),
                       .AN_ACTIVE_LOW(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    function automatic logic [6:0] ref_seg(input logic [3:0] n, input bit hex);
        case (n)
            4'd0:  return 7'h3F;
            4'd1:  return 7'h06;
            4'd2:  return 7'h5B;
            4'd3:  return 7'h4F;
            4'd4:  return 7'h66;
            4'd5:  return 7'h6D;
            4'd6:  return 7'h7D;
            4'd7:  return 7'h07;
            4'd8:  return 7'h7F;
            4'd9:  return 7'h6F;
            4'd10: return hex ? 7'h77 : 7'h00;
            4'd11: return hex ? 7'h7C : 7'h00;
            4'd12: return hex ? 7'h39 : 7'h00;
            4'd13: return hex ? 7'h5E : 7'h00;
            4'd14: return hex ? 7'h79 : 7'h00;
            4'd15: return hex ? 7'h71 : 7'h00;
            default: return 7'h00;
        endcase
    endfunction

    function automatic exp_t mk(input logic [15:0] v, input logic [3:0] d_p,
                                input bit blz, input int d, input bit frm);
        exp_t e;
        bit   sup;
        logic [3:0] nib;
        nib = v[4*d +: 4];
        sup = blz && (d != 0);
        for (int k = d; k < 4; k++) begin
            if (v[4*k +: 4] != 4'h0) sup = 1'b0;
        end
        e.seg_a = sup ? 7'h00 : ref_seg(nib, 1'b1);
        e.seg_b = sup ? 7'h00 : ref_seg(nib, 1'b0);
        e.dp    = d_p[d];
        e.an    = 4'b0001 << d;
        e.frame = frm;
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d_p, input bit blz);
        for (int i = 0; i < 16; i++) sb.push_back(mk(v, d_p, blz, i / 4, i == 0));
    endtask

    task automatic push_inactive(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Compare n consecutive cycles, sampling on the falling edge.
    task automatic check_n(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL scoreboard_empty obs=0 exp=1");
            end else begin
                e = sb.pop_front();
                tests += 3;
                assert ({ia.seg, ia.dp, ia.an, ia.frame} === {e.seg_a, e.dp, e.an, e.frame})
                else begin
                    fails++;
                    $error("FAIL hex_out obs=%h exp=%h", {ia.seg, ia.dp, ia.an, ia.frame},
                           {e.seg_a, e.dp, e.an, e.frame});
                end
                assert ({ib.seg, ib.an, ib.frame} === {e.seg_b, e.an, e.frame})
                else begin
                    fails++;
                    $error("FAIL dec_out obs=%h exp=%h", {ib.seg, ib.an, ib.frame},
                           {e.seg_b, e.an, e.frame});
                end
                assert ({ic.seg, ic.dp, ic.an, ic.frame} === {~e.seg_a, ~e.dp, ~e.an, e.frame})
                else begin
                    fails++;
                    $error("FAIL inv_out obs=%h exp=%h", {ic.seg, ic.dp, ic.an, ic.frame},
                           {~e.seg_a, ~e.dp, ~e.an, e.frame});
                end
            end
            @(negedge clk);
        end
    endtask

    // Check the current frame, issuing a load at cycle 'at' of it.
    task automatic frame_with_load(input logic [15:0] cv, input logic [3:0] cdp, input bit cblz,
                                   input int at, input logic [15:0] nv, input logic [3:0] ndp,
                                   input bit nblz);
        push_frame(cv, cdp, cblz);
        check_n(at);
        value    = nv;
        dp_in    = ndp;
        blank_lz = nblz;
        load     = 1'b1;
        check_n(1);
        load     = 1'b0;
        check_n(15 - at);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
        value = 16'h0000; dp_in = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        push_inactive(1);
        check_n(1);
        // Release with enable high: first edge starts a frame at digit 0.
        rst_n  = 1'b1;
        enable = 1'b1;
        push_inactive(1);
        check_n(1);
        frame_with_load(16'h0000, 4'b0000, 1'b0, 3, 16'h1234, 4'b0101, 1'b0);
        frame_with_load(16'h1234, 4'b0101, 1'b0, 3, 16'hA5F0, 4'b1000, 1'b0);
        frame_with_load(16'hA5F0, 4'b1000, 1'b0, 3, 16'h0005, 4'b0000, 1'b1);
        frame_with_load(16'h0005, 4'b0000, 1'b1, 3, 16'h0000, 4'b0000, 1'b1);
        frame_with_load(16'h0000, 4'b0000, 1'b1, 3, 16'h0105, 4'b0000, 1'b1);
        frame_with_load(16'h0105, 4'b0000, 1'b1, 3, 16'h2222, 4'b0000, 1'b0);
        // Load during the digit-1 slot must not disturb the running frame.
        frame_with_load(16'h2222, 4'b0000, 1'b0, 5, 16'h1111, 4'b0000, 1'b0);
        // Load on the frame-start edge appears at digit 0 of the new frame.
        frame_with_load(16'h1111, 4'b0000, 1'b0, 15, 16'h8888, 4'b1111, 1'b0);
        // Drop enable mid-frame, load while idle, then re-enable.
        for (int i = 0; i < 7; i++) sb.push_back(mk(16'h8888, 4'b1111, 1'b0, i / 4, i == 0));
        check_n(6);
        enable = 1'b0;
        check_n(1);
        push_inactive(4);
        check_n(1);
        value = 16'h4321; dp_in = 4'b0010; load = 1'b1;
        check_n(1);
        load = 1'b0;
        check_n(2);
        enable = 1'b1;
        push_inactive(1);
        push_frame(16'h4321, 4'b0010, 1'b0);
        check_n(17);
        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) sb.push_back(mk(16'h4321, 4'b0010, 1'b0, i / 4, i == 0));
        check_n(5);
        rst_n = 1'b0;
        #1;
        tests += 2;
        assert ({ia.seg, ia.dp, ia.an, ia.frame} === 13'h0000)
        else begin
            fails++;
            $error("FAIL async_rst_hex obs=%h exp=%h", {ia.seg, ia.dp, ia.an, ia.frame}, 13'h0000);
        end
        assert ({ic.seg, ic.dp, ic.an, ic.frame} === {7'h7F, 1'b1, 4'hF, 1'b0})
        else begin
            fails++;
            $error("FAIL async_rst_inv obs=%h exp=%h", {ic.seg, ic.dp, ic.an, ic.frame},
                   {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_inactive(1);
        push_frame(16'h0000, 4'b0000, 1'b0);
        check_n(17);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
